// File: rtl/cnt_down_generic.sv
// Loadable down-counter / countdown timer with start/busy/done handshake.
// Decrements by a sampled step on enabled cycles; reloads or completes at terminal.
module cnt_down_generic #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [CNT_W-1:0] i_start_val,
    input  logic [CNT_W-1:0] i_step,
    input  logic             i_auto_reload,
    input  logic             i_load,
    input  logic             i_en,
    input  logic             i_clear,
    output logic             o_flag,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_start;
    logic [CNT_W-1:0] r_step;
    logic             r_reload;
    logic             r_busy;
    logic             r_done;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_start_nxt;
    logic [CNT_W-1:0] w_step_nxt;
    logic             w_reload_nxt;
    logic [CNT_W-1:0] w_eff_step;
    logic             w_count;
    logic             w_term;

    // A zero step would never terminate, so it counts as one.
    assign w_eff_step = (r_step == '0) ? CNT_ONE : r_step;
    assign w_count    = (r_state == ST_RUN) && i_en && !i_clear && !i_load;
    assign w_term     = (r_cnt < w_eff_step);
    assign o_flag     = w_count && w_term;

    // Next-state and datapath update; clear beats load beats count.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_start_nxt  = r_start;
        w_step_nxt   = r_step;
        w_reload_nxt = r_reload;
        if (i_clear) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
        end else if (i_load) begin
            w_cnt_nxt    = i_start_val;
            w_start_nxt  = i_start_val;
            w_step_nxt   = i_step;
            w_reload_nxt = i_auto_reload;
            w_state_nxt  = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (i_en) begin
                        if (!w_term) begin
                            w_cnt_nxt = r_cnt - w_eff_step;
                        end else if (r_reload) begin
                            w_cnt_nxt = r_start;
                        end else begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = ST_DONE;
                        end
                    end
                end
                ST_DONE: w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_start  <= '0;
            r_step   <= '0;
            r_reload <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_start  <= w_start_nxt;
            r_step   <= w_step_nxt;
            r_reload <= w_reload_nxt;
            r_busy   <= (w_state_nxt == ST_RUN);
            r_done   <= (w_state_nxt == ST_DONE);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule

// File: tb/tb_cnt_down_generic.sv
// Self-checking bench for cnt_down_generic: per-cycle expectations are queued
// when stimulus is driven and compared against the DUT before the next edge.
module tb_cnt_down_generic;

    localparam int unsigned CNT_W = 8;

    logic             i_clk;
    logic             i_rstn;
    logic [CNT_W-1:0] i_start_val;
    logic [CNT_W-1:0] i_step;
    logic             i_auto_reload;
    logic             i_load;
    logic             i_en;
    logic             i_clear;
    logic             o_flag;
    logic             o_busy;
    logic             o_done;
    logic [CNT_W-1:0] o_cnt;

    typedef struct {
        logic [CNT_W-1:0] cnt;
        logic             busy;
        logic             done;
        logic             flag;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    total = 0;
    int    bad   = 0;

    cnt_down_generic #(.CNT_W(CNT_W)) dut (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_start_val  (i_start_val),
        .i_step       (i_step),
        .i_auto_reload(i_auto_reload),
        .i_load       (i_load),
        .i_en         (i_en),
        .i_clear      (i_clear),
        .o_flag       (o_flag),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_cnt        (o_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        total++;
        if (obs !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, req, $time);
        end
    endtask

    // Drive one cycle of inputs (called just after a negedge), queue the outputs
    // expected during this cycle, then compare them before the next posedge.
    task automatic cyc(input string tag, input logic rst, input logic ld,
                       input logic [CNT_W-1:0] sv, input logic [CNT_W-1:0] st,
                       input logic ar, input logic en, input logic clr,
                       input logic [CNT_W-1:0] ecnt, input logic ebusy,
                       input logic edone, input logic eflag);
        exp_t  e;
        exp_t  p;
        string t;
        i_rstn        = rst;
        i_load        = ld;
        i_start_val   = sv;
        i_step        = st;
        i_auto_reload = ar;
        i_en          = en;
        i_clear       = clr;
        e.cnt  = ecnt;
        e.busy = ebusy;
        e.done = edone;
        e.flag = eflag;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        #2;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'(1), 32'(0));
        end else begin
            p = sb_q.pop_front();
            t = tag_q.pop_front();
            chk({t, ".cnt"},  32'(o_cnt),  32'(p.cnt));
            chk({t, ".busy"}, 32'(o_busy), 32'(p.busy));
            chk({t, ".done"}, 32'(o_done), 32'(p.done));
            chk({t, ".flag"}, 32'(o_flag), 32'(p.flag));
        end
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    initial begin
        i_rstn = 1'b0; i_load = 1'b0; i_start_val = '0; i_step = '0;
        i_auto_reload = 1'b0; i_en = 1'b0; i_clear = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);

        // reset state; load while in reset is ignored
        cyc("rst0",     0, 1, 8'd9, 8'd1, 0, 1, 0,  8'd0, 0, 0, 0);
        cyc("rst1",     0, 0, 8'd0, 8'd0, 0, 1, 0,  8'd0, 0, 0, 0);

        // basic countdown N=10 S=3
        cyc("b_load",   1, 1, 8'd10, 8'd3, 0, 1, 0, 8'd0, 0, 0, 0);
        cyc("b_10",     1, 0, 8'd0, 8'd0, 0, 1, 0,  8'd10, 1, 0, 0);
        cyc("b_7",      1, 0, 8'd0, 8'd0, 0, 1, 0,  8'd7, 1, 0, 0);
        cyc("b_4",      1, 0, 8'd0, 8'd0, 0, 1, 0,  8'd4, 1, 0, 0);
        cyc("b_1",      1, 0, 8'd0, 8'd0, 0, 1, 0,  8'd1, 1, 0, 1);
        cyc("b_done",   1, 0, 8'd0, 8'd0, 0, 1, 0,  8'd0, 0, 1, 0);
        cyc("b_idle",   1, 0, 8'd0, 8'd0, 0, 1, 0,  8'd0, 0, 0, 0);
        cyc("b_idle2",  1, 0, 8'd0, 8'd0, 0, 1, 0,  8'd0, 0, 0, 0);

        // periodic N=5 S=5, then clear suppresses the flag
        cyc("p_load",   1, 1, 8'd5, 8'd5, 1, 1, 0,  8'd0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            cyc("p_5",  1, 0, 8'd0, 8'd0, 0, 1, 0,  8'd5, 1, 0, 0);
            cyc("p_0",  1, 0, 8'd0, 8'd0, 0, 1, 0,  8'd0, 1, 0, 1);
        end
        cyc("p_clr",    1, 0, 8'd0, 8'd0, 0, 1, 1,  8'd5, 1, 0, 0);
        cyc("p_idle",   1, 0, 8'd0, 8'd0, 0, 1, 0,  8'd0, 0, 0, 0);

        // step zero treated as one; load in DONE with N=0 S=4
        cyc("z_load",   1, 1, 8'd2, 8'd0, 0, 1, 0,  8'd0, 0, 0, 0);
        cyc("z_2",      1, 0, 8'd0, 8'd0, 0, 1, 0,  8'd2, 1, 0, 0);
        cyc("z_1",      1, 0, 8'd0, 8'd0, 0, 1, 0,  8'd1, 1, 0, 0);
        cyc("z_0",      1, 0, 8'd0, 8'd0, 0, 1, 0,  8'd0, 1, 0, 1);
        cyc("z_dload",  1, 1, 8'd0, 8'd4, 0, 1, 0,  8'd0, 0, 1, 0);
        cyc("z_n0",     1, 0, 8'd0, 8'd0, 0, 1, 0,  8'd0, 1, 0, 1);
        cyc("z_done",   1, 0, 8'd0, 8'd0, 0, 1, 0,  8'd0, 0, 1, 0);
        cyc("z_idle",   1, 0, 8'd0, 8'd0, 0, 1, 0,  8'd0, 0, 0, 0);

        // enable gaps and restart in RUN
        cyc("e_load",   1, 1, 8'd8, 8'd2, 0, 1, 0,  8'd0, 0, 0, 0);
        cyc("e_8",      1, 0, 8'd0, 8'd0, 0, 1, 0,  8'd8, 1, 0, 0);
        cyc("e_6off",   1, 0, 8'd0, 8'd0, 0, 0, 0,  8'd6, 1, 0, 0);
        cyc("e_6",      1, 0, 8'd0, 8'd0, 0, 1, 0,  8'd6, 1, 0, 0);
        cyc("e_rld",    1, 1, 8'd3, 8'd2, 0, 1, 0,  8'd4, 1, 0, 0);
        cyc("e_3off",   1, 0, 8'd0, 8'd0, 0, 0, 0,  8'd3, 1, 0, 0);
        cyc("e_3",      1, 0, 8'd0, 8'd0, 0, 1, 0,  8'd3, 1, 0, 0);
        cyc("e_1off",   1, 0, 8'd0, 8'd0, 0, 0, 0,  8'd1, 1, 0, 0);
        cyc("e_1",      1, 0, 8'd0, 8'd0, 0, 1, 0,  8'd1, 1, 0, 1);
        cyc("e_done",   1, 0, 8'd0, 8'd0, 0, 0, 0,  8'd0, 0, 1, 0);

        // clear and load together: clear wins
        cyc("c_load",   1, 1, 8'd6, 8'd1, 0, 1, 0,  8'd0, 0, 0, 0);
        cyc("c_coll",   1, 1, 8'd9, 8'd1, 0, 1, 1,  8'd6, 1, 0, 0);
        cyc("c_idle",   1, 0, 8'd0, 8'd0, 0, 1, 0,  8'd0, 0, 0, 0);

        // synchronous reset mid-run
        cyc("r_load",   1, 1, 8'd7, 8'd1, 0, 1, 0,  8'd0, 0, 0, 0);
        cyc("r_7",      0, 0, 8'd0, 8'd0, 0, 1, 0,  8'd7, 1, 0, 0);
        cyc("r_ldign",  0, 1, 8'd9, 8'd1, 0, 1, 0,  8'd0, 0, 0, 0);
        cyc("r_after",  1, 0, 8'd0, 8'd0, 0, 1, 0,  8'd0, 0, 0, 0);

        chk("sb_drain", 32'(sb_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cnt_down_generic.md
Name: cnt_down_generic

Overview:
Loadable down-counter/countdown timer with start/busy/done handshake. It complements the up-counting loop counters: a controller loads a start value and step, and the block decrements on each enabled cycle. It flags the terminal position and either reloads (periodic mode) or reports completion. It is used by dataflow controllers for remaining-iteration and timeout tracking.

Parameters:
CNT_W, 8, counter/start/step width in bits

Ports:
i_clk  input  1  clock, all logic on rising edge
i_rstn  input  1  reset, synchronous, active-low
i_start_val  input  CNT_W  start value N, sampled on load
i_step  input  CNT_W  decrement step S, sampled on load; 0 treated as 1
i_auto_reload  input  1  periodic mode select, sampled on load
i_load  input  1  load/start pulse
i_en  input  1  count enable
i_clear  input  1  synchronous abort to zero/IDLE
o_flag  output  1  terminal flag (combinational), next decrement would underflow
o_busy  output  1  high in RUN
o_done  output  1  one-cycle completion pulse
o_cnt  output  CNT_W  current count value

Behaviour:
- Reset (i_rstn=0 at posedge): state IDLE, cnt_q=0, start_q=0, step_q=0, reload_q=0. Outputs while in reset state: o_cnt=0, o_busy=0, o_done=0, o_flag=0. Reset has no effect between edges.
- Registers: cnt_q, start_q, step_q, reload_q, state. eff_step = (step_q==0) ? 1 : step_q.
- State IDLE: o_busy=0, o_done=0. i_en is ignored.
- State RUN: o_busy=1.
- State DONE: lasts exactly one cycle. o_done=1, o_busy=0. Next state is IDLE unless a load or clear is applied.
- Priority at each posedge: reset > i_clear > i_load > count.
- i_clear=1, any state: cnt_q<=0, state<=IDLE. o_flag=0 that cycle. No o_done.
- i_load=1, no clear, any state (restart allowed in RUN and DONE):
  - cnt_q<=i_start_val, start_q<=i_start_val, step_q<=i_step, reload_q<=i_auto_reload.
  - state<=RUN.
  - o_flag=0 that cycle; no count occurs that cycle.
- Count (state RUN, i_en=1, no clear, no load):
  - Terminal when cnt_q < eff_step. o_flag=1 combinationally that same cycle.
  - Not terminal: cnt_q<=cnt_q-eff_step.
  - Terminal and reload_q=1: cnt_q<=start_q, stay RUN.
  - Terminal and reload_q=0: cnt_q<=0, state<=DONE.
- RUN with i_en=0: all registers hold, o_flag=0.
- o_flag is asserted only in RUN, with i_en=1, i_clear=0, i_load=0 and the terminal condition true.
- Arithmetic: CNT_W-bit unsigned. The subtraction is guarded by the terminal check, so it never wraps.
- Sequence length: from load, exactly floor(N/eff_step)+1 enabled cycles reach the flag. N=0 flags on the first enable.
- o_cnt=cnt_q (registered). o_done=(state==DONE) (registered).

Test Plan:
- Basic countdown: N=10, S=3, reload=0, i_en held high after load. o_cnt is 10,7,4,1 on consecutive cycles. o_flag=1 only while cnt=1. Next cycle: DONE, o_done=1, o_cnt=0, o_busy=0. The cycle after: IDLE.
- Periodic mode: N=5, S=5, reload=1, continuous i_en. o_cnt is 5,0,5,0,... with o_flag=1 on every cnt=0 cycle. o_busy stays 1 and o_done never asserts.
- Step zero and zero start: N=2, S=0 gives o_cnt 2,1,0, flag on the 3rd enable, then DONE. N=0, S=4 flags on the first enable, then DONE.
- Enable gaps and restart: N=8, S=2 with i_en toggled 1,0,1. The count holds during i_en=0 (8,6,6,4). i_load with N=3 while cnt=4 gives o_cnt=3 next cycle, still RUN, no o_done.
- Clear vs load collision: in RUN at cnt=6, assert i_clear and i_load together. Next cycle: IDLE, o_cnt=0, o_flag=0 in the collision cycle, no o_done.
- Synchronous reset mid-run: at cnt=7, drive i_rstn=0 between edges. Outputs are unchanged until the next posedge, then o_cnt=0, o_busy=0. i_load with i_rstn=0 is ignored.
